disk_dma_loader: RTL and testbench

- Block-transfer engine between main memory and disk_controller.
- Copies N 32-bit words from disk to memory (load), or from memory to disk (store), one word at a time.
- Drives disk_controller's track/sector/address_in_sector/read/write and consumes read_done/write_done.
- Used by the boot/OS path to load program images; the CPU starts it with a one-cycle start pulse and polls busy/done.

---
 rtl/disk_dma_pkg.sv | 20 ++
 rtl/disk_dma_loader_if.sv | 34 +++
 rtl/disk_dma_loader.sv | 127 ++++++++++++
 tb/tb_disk_dma_loader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/disk_dma_pkg.sv
// Shared constants for the disk/memory block-transfer engine:
// FSM state encodings and disk address field widths.
package disk_dma_pkg;

  localparam int TRACK_W  = 3;
  localparam int SECTOR_W = 5;
  localparam int WORD_W   = 7;
  localparam int DADDR_W  = TRACK_W + SECTOR_W + WORD_W;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_DRD   = 4'd1;
  localparam logic [3:0] ST_MWR   = 4'd2;
  localparam logic [3:0] ST_MRD   = 4'd3;
  localparam logic [3:0] ST_MWAIT = 4'd4;
  localparam logic [3:0] ST_DWR   = 4'd5;
  localparam logic [3:0] ST_NEXT  = 4'd6;
  localparam logic [3:0] ST_DONE  = 4'd7;
  localparam logic [3:0] ST_ERROR = 4'd8;

endpackage

// File: rtl/disk_dma_loader_if.sv
// Disk-controller and main-memory bus seen by the DMA engine.
// master = DMA engine side, slave = disk controller / memory side.
interface disk_dma_loader_if #(
  parameter int MEM_AW = 10
);
  import disk_dma_pkg::*;

  logic [TRACK_W-1:0]  track;
  logic [SECTOR_W-1:0] sector;
  logic [WORD_W-1:0]   address_in_sector;
  logic                read;
  logic                write;
  logic [31:0]         write_value;
  logic [31:0]         read_value;
  logic                read_done;
  logic                write_done;
  logic [MEM_AW-1:0]   mem_addr;
  logic                mem_we;
  logic [31:0]         mem_wdata;
  logic [31:0]         mem_rdata;

  modport master (
    output track, sector, address_in_sector, read, write, write_value,
    output mem_addr, mem_we, mem_wdata,
    input  read_value, read_done, write_done, mem_rdata
  );

  modport slave (
    input  track, sector, address_in_sector, read, write, write_value,
    input  mem_addr, mem_we, mem_wdata,
    output read_value, read_done, write_done, mem_rdata
  );

endinterface

// File: rtl/disk_dma_loader.sv
// Word-at-a-time block copy between disk_controller and main memory,
// started by a one-cycle pulse and polled through busy/done/error.
module disk_dma_loader
  import disk_dma_pkg::*;
#(
  parameter int          MEM_AW  = 10,
  parameter int          CNT_W   = 16,
  parameter logic [15:0] TIMEOUT = 16'd64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                dir,
  input  logic [DADDR_W-1:0]  disk_base,
  input  logic [MEM_AW-1:0]   mem_base,
  input  logic [CNT_W-1:0]    word_count,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [CNT_W-1:0]    words_done,
  disk_dma_loader_if.master   bus
);

  localparam logic [CNT_W-1:0]   CNT_ONE  = 1;
  localparam logic [MEM_AW-1:0]  MEM_ONE  = 1;
  localparam logic [DADDR_W-1:0] DADDR_ONE = 1;

  logic [3:0]         state;
  logic               dir_q;
  logic [DADDR_W-1:0] daddr;
  logic [MEM_AW-1:0]  maddr;
  logic [CNT_W-1:0]   remaining;
  logic [15:0]        tmo;
  logic [31:0]        write_value_q;
  logic [31:0]        mem_wdata_q;
  logic               idle_like;

  assign idle_like = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      dir_q         <= 1'b0;
      daddr         <= '0;
      maddr         <= '0;
      remaining     <= '0;
      tmo           <= '0;
      write_value_q <= '0;
      mem_wdata_q   <= '0;
      words_done    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            dir_q      <= dir;
            daddr      <= disk_base;
            maddr      <= mem_base;
            remaining  <= word_count;
            words_done <= '0;
            tmo        <= '0;
            if (word_count == '0) state <= ST_DONE;
            else if (dir)         state <= ST_MRD;
            else                  state <= ST_DRD;
          end
        end
        ST_DRD: begin
          if (bus.read_done) begin
            mem_wdata_q <= bus.read_value;
            state       <= ST_MWR;
          end else if (tmo == TIMEOUT - 16'd1) begin
            state <= ST_ERROR;
          end else begin
            tmo <= tmo + 16'd1;
          end
        end
        ST_MWR:   state <= ST_NEXT;
        ST_MRD:   state <= ST_MWAIT;
        ST_MWAIT: begin
          write_value_q <= bus.mem_rdata;
          tmo           <= '0;
          state         <= ST_DWR;
        end
        ST_DWR: begin
          if (bus.write_done) begin
            state <= ST_NEXT;
          end else if (tmo == TIMEOUT - 16'd1) begin
            state <= ST_ERROR;
          end else begin
            tmo <= tmo + 16'd1;
          end
        end
        ST_NEXT: begin
          words_done <= words_done + CNT_ONE;
          maddr      <= maddr + MEM_ONE;
          remaining  <= remaining - CNT_ONE;
          // The last word is checked before overflow, so a transfer ending
          // exactly at 7FFF still completes cleanly.
          if (remaining == CNT_ONE) begin
            state <= ST_DONE;
          end else if (daddr == '1) begin
            state <= ST_ERROR;
          end else begin
            daddr <= daddr + DADDR_ONE;
            tmo   <= '0;
            state <= dir_q ? ST_MRD : ST_DRD;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy  = !idle_like;
  assign done  = (state == ST_DONE);
  assign error = (state == ST_ERROR);

  assign bus.track             = daddr[DADDR_W-1 -: TRACK_W];
  assign bus.sector            = daddr[WORD_W +: SECTOR_W];
  assign bus.address_in_sector = daddr[WORD_W-1:0];
  assign bus.read              = (state == ST_DRD);
  assign bus.write             = (state == ST_DWR);
  assign bus.write_value       = write_value_q;
  assign bus.mem_addr          = maddr;
  assign bus.mem_we            = (state == ST_MWR);
  assign bus.mem_wdata         = mem_wdata_q;

endmodule

// File: tb/tb_disk_dma_loader.sv
// Directed bench for disk_dma_loader with a behavioural disk controller
// (fixed 3-cycle acknowledge) and a one-cycle-latency memory.
module tb_disk_dma_loader;
  import disk_dma_pkg::*;

  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        dir = 1'b0;
  logic [14:0] disk_base = '0;
  logic [9:0]  mem_base = '0;
  logic [15:0] word_count = '0;
  logic        busy, done, error;
  logic [15:0] words_done;

  int checks = 0;
  int failures = 0;

  disk_dma_loader_if #(.MEM_AW(10)) bus ();

  disk_dma_loader #(
    .MEM_AW (10),
    .CNT_W  (16),
    .TIMEOUT(16'd64)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dir       (dir),
    .disk_base (disk_base),
    .mem_base  (mem_base),
    .word_count(word_count),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .words_done(words_done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] disk [0:32767];
  logic [31:0] mem  [0:1023];
  logic        disk_en = 1'b1;
  logic        pk_disk = 1'b0;
  logic        pk_mem = 1'b0;
  logic [14:0] pk_addr = '0;
  logic [31:0] pk_data = '0;
  logic [1:0]  lat;
  logic [14:0] cur_addr;
  logic [14:0] log_addr [0:63];
  logic        log_wr   [0:63];
  logic [31:0] log_val  [0:63];
  int          log_n = 0;

  assign cur_addr = {bus.track, bus.sector, bus.address_in_sector};

  always @(posedge clk) begin
    bus.read_done  <= 1'b0;
    bus.write_done <= 1'b0;
    if (pk_disk) disk[pk_addr] <= pk_data;
    if (reset) begin
      lat <= '0;
    end else if (disk_en && (bus.read || bus.write) && !bus.read_done && !bus.write_done) begin
      if (lat == 2'd2) begin
        lat <= '0;
        log_addr[log_n[5:0]] <= cur_addr;
        log_wr[log_n[5:0]]   <= bus.write;
        log_val[log_n[5:0]]  <= bus.read ? disk[cur_addr] : bus.write_value;
        log_n <= log_n + 1;
        if (bus.read) begin
          bus.read_done  <= 1'b1;
          bus.read_value <= disk[cur_addr];
        end else begin
          bus.write_done <= 1'b1;
          disk[cur_addr] <= bus.write_value;
        end
      end else begin
        lat <= lat + 2'd1;
      end
    end else begin
      lat <= '0;
    end
  end

  always @(posedge clk) begin
    if (pk_mem) mem[pk_addr[9:0]] <= pk_data;
    else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input bit is_disk, input logic [14:0] addr, input logic [31:0] data);
    @(negedge clk);
    pk_disk = is_disk;
    pk_mem  = !is_disk;
    pk_addr = addr;
    pk_data = data;
    @(negedge clk);
    pk_disk = 1'b0;
    pk_mem  = 1'b0;
  endtask

  // Returns busy cycles and cycles with read/write asserted.
  task automatic run_xfer(input logic d, input logic [14:0] dbase, input logic [9:0] mbase,
                          input logic [15:0] cnt, output int busy_cyc, output int rd_hi, output int wr_hi);
    int cyc;
    @(negedge clk);
    dir = d; disk_base = dbase; mem_base = mbase; word_count = cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; rd_hi = 0; wr_hi = 0;
    while (cyc < 2000) begin
      if (!busy) break;
      if (bus.read)  rd_hi++;
      if (bus.write) wr_hi++;
      @(negedge clk);
      cyc++;
    end
    check_eq("xfer_ends", {31'd0, busy}, 32'd0);
    busy_cyc = cyc - 1;
  endtask

  int bc, rh, wh, base;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_eq("rst_busy",  {31'd0, busy}, 0);
    check_eq("rst_done",  {31'd0, done}, 0);
    check_eq("rst_error", {31'd0, error}, 0);
    check_eq("rst_rw",    {30'd0, bus.read, bus.write}, 0);
    check_eq("rst_we",    {31'd0, bus.mem_we}, 0);
    check_eq("rst_wdone", {16'd0, words_done}, 0);
    check_eq("rst_daddr", {17'd0, bus.track, bus.sector, bus.address_in_sector}, 0);
    check_eq("rst_wval",  bus.write_value, 0);
    check_eq("rst_maddr", {22'd0, bus.mem_addr}, 0);
    check_eq("rst_mwdata", bus.mem_wdata, 0);

    // Load three words
    poke(1'b1, 15'd0, 32'h1000_0008);
    poke(1'b1, 15'd1, 32'd300);
    poke(1'b1, 15'd2, 32'h7E00_0065);
    base = log_n;
    run_xfer(1'b0, 15'd0, 10'h040, 16'd3, bc, rh, wh);
    check_eq("ld_mem0", mem[10'h040], 32'h1000_0008);
    check_eq("ld_mem1", mem[10'h041], 32'd300);
    check_eq("ld_mem2", mem[10'h042], 32'h7E00_0065);
    check_eq("ld_done", {31'd0, done}, 1);
    check_eq("ld_err",  {31'd0, error}, 0);
    check_eq("ld_wdone", {16'd0, words_done}, 3);
    check_eq("ld_cycles", bc, 18);
    check_eq("ld_nacc", log_n - base, 3);
    check_eq("ld_nowrite", wh, 0);

    // Sector carry 127 -> 0
    poke(1'b1, 15'h007F, 32'hAAAA_0001);
    poke(1'b1, 15'h0080, 32'hAAAA_0002);
    base = log_n;
    run_xfer(1'b0, 15'h007F, 10'h100, 16'd2, bc, rh, wh);
    check_eq("sc_addr0", {17'd0, log_addr[base[5:0]]}, 32'h007F);
    check_eq("sc_addr1", {17'd0, log_addr[base[5:0] + 6'd1]}, 32'h0080);
    check_eq("sc_mem1", mem[10'h101], 32'hAAAA_0002);
    check_eq("sc_done", {31'd0, done}, 1);

    // Store one word
    poke(1'b0, 15'h0010, 32'hDEAD_BEEF);
    base = log_n;
    run_xfer(1'b1, 15'h0105, 10'h010, 16'd1, bc, rh, wh);
    check_eq("st_nacc", log_n - base, 1);
    check_eq("st_iswr", {31'd0, log_wr[base[5:0]]}, 1);
    check_eq("st_addr", {17'd0, log_addr[base[5:0]]}, {17'd0, 3'd0, 5'd2, 7'd5});
    check_eq("st_val", log_val[base[5:0]], 32'hDEAD_BEEF);
    check_eq("st_disk", disk[15'h0105], 32'hDEAD_BEEF);
    check_eq("st_done", {31'd0, done}, 1);
    check_eq("st_cycles", bc, 7);
    check_eq("st_noread", rh, 0);

    // Timeout on read
    disk_en = 1'b0;
    run_xfer(1'b0, 15'd3, 10'h050, 16'd1, bc, rh, wh);
    check_eq("to_error", {31'd0, error}, 1);
    check_eq("to_done",  {31'd0, done}, 0);
    check_eq("to_read",  {31'd0, bus.read}, 0);
    check_eq("to_rdcyc", rh, TMO);
    check_eq("to_wdone", {16'd0, words_done}, 0);
    disk_en = 1'b1;

    // Overflow past the last disk word
    poke(1'b1, 15'h7FFF, 32'h5555_AAAA);
    base = log_n;
    run_xfer(1'b0, 15'h7FFF, 10'h200, 16'd2, bc, rh, wh);
    check_eq("ov_error", {31'd0, error}, 1);
    check_eq("ov_done",  {31'd0, done}, 0);
    check_eq("ov_wdone", {16'd0, words_done}, 1);
    check_eq("ov_mem",   mem[10'h200], 32'h5555_AAAA);
    check_eq("ov_nacc",  log_n - base, 1);

    // Zero-length transfer
    base = log_n;
    run_xfer(1'b0, 15'd0, 10'h300, 16'd0, bc, rh, wh);
    check_eq("z_done",  {31'd0, done}, 1);
    check_eq("z_error", {31'd0, error}, 0);
    check_eq("z_cycles", bc, 0);
    check_eq("z_nacc", log_n - base, 0);

    // Reset while waiting in DRD
    disk_en = 1'b0;
    @(negedge clk);
    dir = 1'b0; disk_base = 15'd4; mem_base = 10'h060; word_count = 16'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("mr_read_pre", {31'd0, bus.read}, 1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("mr_read", {31'd0, bus.read}, 0);
    check_eq("mr_busy", {31'd0, busy}, 0);
    check_eq("mr_done", {31'd0, done}, 0);
    reset = 1'b0;
    disk_en = 1'b1;
    @(negedge clk);
    check_eq("mr_idle", {29'd0, busy, done, error}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
